// File: rtl/serial_writer_pkg.sv
// rtl/serial_writer_pkg.sv - shared state encoding and helpers for the serial writer
package serial_writer_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // Position within the shift register of the bit sent at step `index`.
  function automatic int sel_bit(input int index, input int width, input bit msb_first);
    return msb_first ? (width - 1 - index) : index;
  endfunction

  function automatic bit width_ok(input int width, input int cwidth);
    return (width >= 2) && ((longint'(1) << cwidth) >= longint'(width));
  endfunction

endpackage

// File: rtl/serial_writer_hold.sv
// rtl/serial_writer_hold.sv - one-word holding buffer between the host and the shifter
module serial_writer_hold
  import serial_writer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full,
  output logic             load_ready
);

  // A push on the same edge as a pop re-fills the buffer, so push wins.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (clear) begin
      hold_full <= 1'b0;
    end else if (push) begin
      hold_data <= push_data;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end

  assign load_ready = !hold_full;

endmodule

// File: rtl/serial_writer.sv
// rtl/serial_writer.sv - parallel-in serial-out word writer with load handshake and abort
module serial_writer
  import serial_writer_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int CWIDTH     = 6,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             abort,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             mosi,
  output logic             busy,
  output logic             done
);

  if (!width_ok(WIDTH, CWIDTH)) begin : g_bad_width
    $error("serial_writer: WIDTH must be >= 2 and addressable with CWIDTH bits");
  end

  localparam logic [CWIDTH-1:0] LAST = CWIDTH'(WIDTH - 1);

  logic [0:0]        state;
  logic [CWIDTH-1:0] index;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  hold_data;
  logic              hold_full;
  logic              push;
  logic              pop;
  logic              last_step;
  logic [CWIDTH-1:0] bit_pos;

  assign last_step = (state == SHIFT) && enable && (index == LAST);
  assign push      = load_valid && load_ready && !abort;
  assign pop       = !abort && hold_full && ((state == IDLE) || last_step);

  serial_writer_hold #(.WIDTH(WIDTH)) u_hold (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .clear      (abort),
    .push       (push),
    .pop        (pop),
    .push_data  (load_data),
    .hold_data  (hold_data),
    .hold_full  (hold_full),
    .load_ready (load_ready)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= '0;
      shreg <= '0;
      done  <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      index <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_full) begin
            shreg <= hold_data;
            index <= '0;
            state <= SHIFT;
          end
        end
        default: begin
          if (enable) begin
            if (index == LAST) begin
              done  <= 1'b1;
              index <= '0;
              // Reload straight from hold so back-to-back words leave no idle gap.
              if (hold_full) shreg <= hold_data;
              else           state <= IDLE;
            end else begin
              index <= index + CWIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  assign bit_pos = CWIDTH'(sel_bit(int'(index), WIDTH, MSB_FIRST));
  assign mosi    = (state == SHIFT) ? shreg[bit_pos] : IDLE_LEVEL;
  assign busy    = (state == SHIFT);

endmodule

// File: tb/tb_serial_writer.sv
// tb/tb_serial_writer.sv - self-checking bench for serial_writer (LSB/idle-0 and MSB/idle-1 instances)
module tb_serial_writer;

  logic       sclk;
  logic       rst_n;
  logic       en;
  logic       ab;
  logic       lv;
  logic [7:0] ld;
  logic [1:0] mosi_v, busy_v, done_v, lr_v;

  localparam bit [1:0] MSB_F  = 2'b10;
  localparam bit [1:0] IDLE_L = 2'b10;

  serial_writer #(.WIDTH(8), .CWIDTH(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
    .sclk(sclk), .rst_n(rst_n), .enable(en), .abort(ab), .load_valid(lv),
    .load_ready(lr_v[0]), .load_data(ld), .mosi(mosi_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  serial_writer #(.WIDTH(8), .CWIDTH(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
    .sclk(sclk), .rst_n(rst_n), .enable(en), .abort(ab), .load_valid(lv),
    .load_ready(lr_v[1]), .load_data(ld), .mosi(mosi_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Word-level model: the word on the line, how many of its bits have gone, and the held word.
  typedef struct packed {
    bit         shifting;
    logic [7:0] word;
    int         sent;
    bit         held;
    logic [7:0] hword;
    bit         done;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t step(input mdl_t c, input bit ab_i, input bit en_i,
                                input bit lv_i, input logic [7:0] ld_i);
    mdl_t n;
    n = c;
    n.done = 1'b0;
    if (ab_i) begin
      n.shifting = 1'b0;
      n.sent     = 0;
      n.held     = 1'b0;
      return n;
    end
    if (!c.shifting && c.held) begin
      n.shifting = 1'b1;
      n.word     = c.hword;
      n.sent     = 0;
      n.held     = 1'b0;
    end else if (c.shifting && en_i) begin
      n.sent = c.sent + 1;
      if (n.sent == 8) begin
        n.done = 1'b1;
        n.sent = 0;
        if (c.held) begin
          n.word = c.hword;
          n.held = 1'b0;
        end else begin
          n.shifting = 1'b0;
        end
      end
    end
    if (lv_i && !c.held) begin
      n.held  = 1'b1;
      n.hword = ld_i;
    end
    return n;
  endfunction

  function automatic mdl_t reset_mdl();
    mdl_t r;
    r = '0;
    return r;
  endfunction

  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= reset_mdl();
      m1 <= reset_mdl();
    end else begin
      m0 <= step(m0, ab, en, lv, ld);
      m1 <= step(m1, ab, en, lv, ld);
    end
  end

  function automatic logic exp_mosi(input mdl_t c, input bit msb, input bit idle);
    if (!c.shifting) return idle;
    return msb ? c.word[7 - c.sent] : c.word[c.sent];
  endfunction

  int          n_assert;
  int          n_fail;
  int          nbits, bcnt, dcnt0, dcnt1;
  logic [31:0] seq0, seq1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    int t;
    t = 0;
    while (lr_v != 2'b11 && t < 100) begin
      tick();
      t++;
    end
    check("send_ready_timeout", 32'(t < 100), 32'd1);
    lv = 1'b1;
    ld = w;
    tick();
    lv = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy_v != 2'b00 || lr_v != 2'b11) && t < 200) begin
      tick();
      t++;
    end
    check("idle_timeout", 32'(t < 200), 32'd1);
    tick();
  endtask

  int b_nbits, b_bcnt, b_d0, b_d1;

  task automatic mark();
    b_nbits = nbits;
    b_bcnt  = bcnt;
    b_d0    = dcnt0;
    b_d1    = dcnt1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    nbits = 0; bcnt = 0; dcnt0 = 0; dcnt1 = 0;
    seq0 = '0; seq1 = '0;
    rst_n = 1'b0; en = 1'b1; ab = 1'b0; lv = 1'b0; ld = '0;

    fork
      forever begin
        @(negedge sclk);
        check("mosi0",  32'(mosi_v[0]), 32'(exp_mosi(m0, MSB_F[0], IDLE_L[0])));
        check("mosi1",  32'(mosi_v[1]), 32'(exp_mosi(m1, MSB_F[1], IDLE_L[1])));
        check("busy0",  32'(busy_v[0]), 32'(m0.shifting));
        check("busy1",  32'(busy_v[1]), 32'(m1.shifting));
        check("done0",  32'(done_v[0]), 32'(m0.done));
        check("done1",  32'(done_v[1]), 32'(m1.done));
        check("ready0", 32'(lr_v[0]),   32'(!m0.held));
        check("ready1", 32'(lr_v[1]),   32'(!m1.held));
        if (rst_n && busy_v[0]) bcnt++;
        if (rst_n && busy_v[0] && en) begin
          nbits++;
          seq0 = {seq0[30:0], mosi_v[0]};
          seq1 = {seq1[30:0], mosi_v[1]};
        end
        if (done_v[0]) dcnt0++;
        if (done_v[1]) dcnt1++;
      end
    join_none

    repeat (3) tick();
    check("rst_mosi",  32'(mosi_v), 32'h2);
    check("rst_busy",  32'(busy_v), 32'h0);
    check("rst_done",  32'(done_v), 32'h0);
    check("rst_ready", 32'(lr_v),   32'h3);
    rst_n = 1'b1;
    tick();

    // Single word A5 on both bit orders (A5 reads the same either way).
    mark();
    send(8'hA5);
    check("lat_busy_lo", 32'(busy_v), 32'h0);
    tick();
    check("lat_busy_hi", 32'(busy_v), 32'h3);
    check("lat_first",   32'(mosi_v), 32'h3);
    wait_idle();
    check("a5_nbits", 32'(nbits - b_nbits), 32'd8);
    check("a5_seq0",  {24'h0, seq0[7:0]},   32'hA5);
    check("a5_seq1",  {24'h0, seq1[7:0]},   32'hA5);
    check("a5_done0", 32'(dcnt0 - b_d0),    32'd1);
    check("a5_done1", 32'(dcnt1 - b_d1),    32'd1);

    // Back-to-back 0F then F0, second accepted while the first shifts.
    mark();
    send(8'h0F);
    send(8'hF0);
    wait_idle();
    check("b2b_nbits", 32'(nbits - b_nbits), 32'd16);
    check("b2b_busy",  32'(bcnt - b_bcnt),   32'd16);
    check("b2b_seq0",  {16'h0, seq0[15:0]},  32'hF00F);
    check("b2b_seq1",  {16'h0, seq1[15:0]},  32'h0FF0);
    check("b2b_done0", 32'(dcnt0 - b_d0),    32'd2);
    check("b2b_done1", 32'(dcnt1 - b_d1),    32'd2);

    // Stall three cycles at index 4 of 3C.
    mark();
    send(8'h3C);
    repeat (5) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", 32'(mosi_v), 32'h3);
      tick();
    end
    check("stall_hold_end", 32'(mosi_v), 32'h3);
    en = 1'b1;
    wait_idle();
    check("stall_nbits", 32'(nbits - b_nbits), 32'd8);
    check("stall_busy",  32'(bcnt - b_bcnt),   32'd11);
    check("stall_seq0",  {24'h0, seq0[7:0]},   32'h3C);
    check("stall_seq1",  {24'h0, seq1[7:0]},   32'h3C);
    check("stall_done0", 32'(dcnt0 - b_d0),    32'd1);

    // Abort at index 2 with a word held.
    mark();
    send(8'h55);
    send(8'hAA);
    tick();
    check("abort_held", 32'(lr_v), 32'h0);
    ab = 1'b1;
    tick();
    ab = 1'b0;
    check("abort_busy",  32'(busy_v), 32'h0);
    check("abort_mosi",  32'(mosi_v), 32'h2);
    check("abort_ready", 32'(lr_v),   32'h3);
    repeat (10) tick();
    check("abort_nbits", 32'(nbits - b_nbits), 32'd3);
    check("abort_bcnt",  32'(bcnt - b_bcnt),   32'd3);
    check("abort_done",  32'((dcnt0 - b_d0) + (dcnt1 - b_d1)), 32'd0);

    // Asynchronous reset in the middle of a word.
    send(8'hA5);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mosi",  32'(mosi_v), 32'h2);
    check("arst_busy",  32'(busy_v), 32'h0);
    check("arst_ready", 32'(lr_v),   32'h3);
    check("arst_done",  32'(done_v), 32'h0);
    mark();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("arst_nbits", 32'(nbits - b_nbits), 32'd0);
    check("arst_bcnt",  32'(bcnt - b_bcnt),   32'd0);
    check("arst_dcnt",  32'((dcnt0 - b_d0) + (dcnt1 - b_d1)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
